// File: rtl/rx_activity_monitor_pkg.sv
// Shared types and constants for the RX stream activity monitors.
// Polarity constants are also consumed by the configuration/reset block.
package rx_activity_monitor_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } rx_state_t;

  localparam int PKT_CNT_W  = 32;
  localparam int BYTE_CNT_W = 48;
  localparam int LEN_W      = 16;
  localparam int TIMER_W    = 32;

  localparam logic RESET  = 1'b0;
  localparam logic ACTIVE = 1'b1;

  // Saturating increment for the packet/error counters.
  function automatic logic [PKT_CNT_W-1:0] sat_inc(input logic [PKT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rx_activity_monitor_keep_popcount.sv
// Combinational popcount of an AXI-Stream tkeep mask; no state, reusable
// by any stream monitor that needs a per-beat byte count.
module keep_popcount #(
  parameter int KW = 64,
  parameter int CW = $clog2(KW + 1)
) (
  input  logic [KW-1:0] keep,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < KW; i++) begin
      count = count + CW'(keep[i]);
    end
  end

endmodule

// File: rtl/rx_activity_monitor.sv
// Passive tap on a CMAC RX AXI-Stream: derives the traffic `active` level
// and keeps packet/error/byte counters plus the last packet length.
module rx_activity_monitor
  import rx_activity_monitor_pkg::*;
#(
  parameter int CLK_HZ     = 322265625,
  parameter int IDLE_USECS = 1000,
  parameter int DW         = 512
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rx_tvalid,
  input  logic                  rx_tlast,
  input  logic                  rx_tuser,
  input  logic [DW/8-1:0]       rx_tkeep,
  input  logic                  clear,
  output logic                  active,
  output logic [PKT_CNT_W-1:0]  pkt_count,
  output logic [PKT_CNT_W-1:0]  err_count,
  output logic [BYTE_CNT_W-1:0] byte_total,
  output logic [LEN_W-1:0]      last_pkt_len,
  output rx_state_t             dbg_state
);

  // Stream contract: no tready, so every cycle with rx_tvalid=1 is an
  // accepted beat; rx_tlast/rx_tuser/rx_tkeep are ignored when rx_tvalid=0.

  localparam int KW     = DW / 8;
  localparam int BCW    = $clog2(KW + 1);
  localparam int LEN_SW = LEN_W + 1;
  localparam logic [TIMER_W-1:0] IDLE_CYCLES = TIMER_W'((CLK_HZ / 1000000) * IDLE_USECS);

  logic [BCW-1:0] beat_bytes;

  keep_popcount #(.KW(KW), .CW(BCW)) u_popcount (
    .keep  (rx_tkeep),
    .count (beat_bytes)
  );

  rx_state_t             state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  active_q, active_d;
  logic [LEN_W-1:0]      cur_len_q, cur_len_d;
  logic [LEN_W-1:0]      last_len_q, last_len_d;
  logic [PKT_CNT_W-1:0]  pkt_count_q, pkt_count_d;
  logic [PKT_CNT_W-1:0]  err_count_q, err_count_d;
  logic [BYTE_CNT_W-1:0] byte_total_q, byte_total_d;

  logic                  beat;
  logic                  eop;
  logic [LEN_SW-1:0]     len_sum;
  logic [LEN_W-1:0]      len_sat;
  logic [PKT_CNT_W-1:0]  pkt_base;
  logic [PKT_CNT_W-1:0]  err_base;
  logic [BYTE_CNT_W-1:0] byte_base;

  always_comb begin
    beat    = rx_tvalid;
    eop     = rx_tvalid & rx_tlast;
    len_sum = {1'b0, cur_len_q} + LEN_SW'(beat_bytes);
    len_sat = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

    cur_len_d  = cur_len_q;
    last_len_d = last_len_q;
    if (beat) begin
      cur_len_d = eop ? '0 : len_sat;
    end
    if (eop) begin
      last_len_d = len_sat;
    end

    // A clear coinciding with an event leaves just that event's contribution.
    pkt_base  = clear ? '0 : pkt_count_q;
    err_base  = clear ? '0 : err_count_q;
    byte_base = clear ? '0 : byte_total_q;

    pkt_count_d  = eop ? sat_inc(pkt_base) : pkt_base;
    err_count_d  = (eop && rx_tuser) ? sat_inc(err_base) : err_base;
    byte_total_d = beat ? byte_base + BYTE_CNT_W'(beat_bytes) : byte_base;
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    active_d = active_q;
    case (state_q)
      S_IDLE: begin
        if (beat) begin
          timer_d  = IDLE_CYCLES;
          active_d = ACTIVE;
          state_d  = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (beat) begin
          timer_d = IDLE_CYCLES;
        end else if (timer_q == '0) begin
          active_d = ~ACTIVE;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn == RESET) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      active_q     <= ~ACTIVE;
      cur_len_q    <= '0;
      last_len_q   <= '0;
      pkt_count_q  <= '0;
      err_count_q  <= '0;
      byte_total_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      active_q     <= active_d;
      cur_len_q    <= cur_len_d;
      last_len_q   <= last_len_d;
      pkt_count_q  <= pkt_count_d;
      err_count_q  <= err_count_d;
      byte_total_q <= byte_total_d;
    end
  end

  assign active       = active_q;
  assign pkt_count    = pkt_count_q;
  assign err_count    = err_count_q;
  assign byte_total   = byte_total_q;
  assign last_pkt_len = last_len_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rx_activity_monitor.sv
// Directed bench for rx_activity_monitor with IDLE_CYCLES = 20
// (CLK_HZ = 10 MHz, IDLE_USECS = 2); expected values are hand-computed.
module tb_rx_activity_monitor;
  import rx_activity_monitor_pkg::*;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam logic [KW-1:0] KEEP_ALL = '1;

  logic            clk;
  logic            resetn;
  logic            rx_tvalid;
  logic            rx_tlast;
  logic            rx_tuser;
  logic [KW-1:0]   rx_tkeep;
  logic            clear;
  logic            active;
  logic [31:0]     pkt_count;
  logic [31:0]     err_count;
  logic [47:0]     byte_total;
  logic [15:0]     last_pkt_len;
  rx_state_t       dbg_state;

  int checks;
  int errors;

  rx_activity_monitor #(
    .CLK_HZ     (10000000),
    .IDLE_USECS (2),
    .DW         (DW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rx_tvalid    (rx_tvalid),
    .rx_tlast     (rx_tlast),
    .rx_tuser     (rx_tuser),
    .rx_tkeep     (rx_tkeep),
    .clear        (clear),
    .active       (active),
    .pkt_count    (pkt_count),
    .err_count    (err_count),
    .byte_total   (byte_total),
    .last_pkt_len (last_pkt_len),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;
    rx_tkeep  = '0;
    clear     = 1'b0;
  endtask

  task automatic drive(input logic v, input logic l, input logic u, input logic [KW-1:0] k, input logic c);
    rx_tvalid = v;
    rx_tlast  = l;
    rx_tuser  = u;
    rx_tkeep  = k;
    clear     = c;
    step();
    idle_inputs();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    step();
    step();
    resetn = 1'b1;
  endtask

  // Cycles until active falls, bounded so a stuck DUT still reaches the summary.
  task automatic wait_drop(output int n);
    n = 0;
    while (active === 1'b1 && n < 60) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int lows;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // reset state
    check("rst_active", active, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_err", err_count, 0);
    check("rst_bytes", byte_total, 0);
    check("rst_len", last_pkt_len, 0);
    check("rst_state", dbg_state, S_IDLE);

    // single-beat 64-byte packet and idle timeout
    drive(1'b1, 1'b1, 1'b0, KEEP_ALL, 1'b0);
    check("s1_pkt", pkt_count, 1);
    check("s1_err", err_count, 0);
    check("s1_bytes", byte_total, 64);
    check("s1_len", last_pkt_len, 64);
    check("s1_active_rise", active, 1);
    check("s1_state", dbg_state, S_ACTIVE);
    wait_drop(n);
    check("s1_drop_cycles", n, 21);
    check("s1_state_idle", dbg_state, S_IDLE);

    // clear alone zeroes counters, keeps last_pkt_len
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("clr_pkt", pkt_count, 0);
    check("clr_bytes", byte_total, 0);
    check("clr_len_kept", last_pkt_len, 64);
    check("clr_active_kept", active, 0);

    // 3-beat packet 64+64+5 with error
    drive(1'b1, 1'b0, 1'b0, KEEP_ALL, 1'b0);
    check("s2_len_mid", last_pkt_len, 64);
    check("s2_pkt_mid", pkt_count, 0);
    drive(1'b1, 1'b0, 1'b0, KEEP_ALL, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 64'h1F, 1'b0);
    check("s2_len", last_pkt_len, 133);
    check("s2_err", err_count, 1);
    check("s2_pkt", pkt_count, 1);
    check("s2_bytes", byte_total, 133);
    wait_drop(n);
    check("s2_drop_cycles", n, 21);

    // beats every 20 cycles keep active high for 200 cycles
    lows = 0;
    for (int p = 0; p < 10; p++) begin
      drive(1'b1, 1'b0, 1'b0, 64'h1, 1'b0);
      if (active !== 1'b1) lows++;
      if (p < 9) begin
        for (int i = 0; i < 19; i++) begin
          step();
          if (active !== 1'b1) lows++;
        end
      end
    end
    check("s3_active_low_cycles", lows, 0);
    check("s3_bytes", byte_total, 143);
    wait_drop(n);
    check("s3_drop_cycles", n, 21);

    // saturation of pkt_count
    do_reset();
    force dut.pkt_count_q = 32'hFFFF_FFFD;
    #1;
    release dut.pkt_count_q;
    drive(1'b1, 1'b1, 1'b0, 64'hF, 1'b0);
    check("sat_pkt_1", pkt_count, 32'hFFFF_FFFE);
    drive(1'b1, 1'b1, 1'b0, 64'hF, 1'b0);
    check("sat_pkt_2", pkt_count, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 1'b0, 64'hF, 1'b0);
    check("sat_pkt_3", pkt_count, 32'hFFFF_FFFF);
    check("sat_bytes", byte_total, 12);

    // clear together with a tlast beat
    drive(1'b1, 1'b1, 1'b1, 64'hFF, 1'b1);
    check("clrev_pkt", pkt_count, 1);
    check("clrev_err", err_count, 1);
    check("clrev_bytes", byte_total, 8);
    check("clrev_len", last_pkt_len, 8);

    // reset mid-packet, with a beat presented during reset
    drive(1'b1, 1'b0, 1'b0, KEEP_ALL, 1'b0);
    drive(1'b1, 1'b0, 1'b0, KEEP_ALL, 1'b0);
    resetn    = 1'b0;
    rx_tvalid = 1'b1;
    rx_tlast  = 1'b1;
    rx_tkeep  = KEEP_ALL;
    step();
    check("rstmid_active", active, 0);
    check("rstmid_pkt", pkt_count, 0);
    check("rstmid_bytes", byte_total, 0);
    check("rstmid_len", last_pkt_len, 0);
    resetn = 1'b1;
    idle_inputs();
    step();
    drive(1'b1, 1'b1, 1'b0, 64'h3FF, 1'b0);
    check("post_rst_len", last_pkt_len, 10);
    check("post_rst_pkt", pkt_count, 1);
    check("post_rst_bytes", byte_total, 10);
    check("post_rst_active", active, 1);

    // tvalid=0 ignores everything else
    drive(1'b0, 1'b1, 1'b1, KEEP_ALL, 1'b0);
    check("novalid_pkt", pkt_count, 1);
    check("novalid_err", err_count, 0);
    check("novalid_bytes", byte_total, 10);
    check("novalid_len", last_pkt_len, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
